// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: major opcodes and instruction formats.
package rv32i_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int IMM_W = 21;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_X
  } fmt_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: assembles the 21-bit sign-extended
// immediate for the given instruction format. The opcode field is not needed
// here (the format already encodes it), so only bits [31:7] come in.
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:7]      instruction,
  input  fmt_t             format,
  output logic [IMM_W-1:0] imm
);

  // Select and sign-extend the immediate bits for the current format.
  always_comb begin
    imm = '0;
    unique case (format)
      FMT_I: imm = {{9{instruction[31]}}, instruction[31:20]};
      FMT_S: imm = {{9{instruction[31]}}, instruction[31:25], instruction[11:7]};
      FMT_B: imm = {{8{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
      // Upper field left unshifted; the consumer applies the <<12.
      FMT_U: imm = {instruction[31], instruction[31:12]};
      FMT_J: imm = {instruction[31], instruction[19:12], instruction[20],
                    instruction[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/riscv_decoder.sv
// Registered RV32I field decoder: classifies the format from the opcode,
// masks out fields the format does not carry and registers all outputs.
module riscv_decoder
  import rv32i_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instruction,
  output logic [2:0]       func3,
  output logic [6:0]       func7,
  output logic [6:0]       opcode,
  output logic [4:0]       r1,
  output logic [4:0]       r2,
  output logic [4:0]       rd,
  output logic [IMM_W-1:0] imm,
  output logic             size
);

  fmt_t             fmt;
  logic             is_shift;
  logic [2:0]       func3_d;
  logic [6:0]       func7_d;
  logic [4:0]       r1_d;
  logic [4:0]       r2_d;
  logic [4:0]       rd_d;
  logic [IMM_W-1:0] imm_d;
  logic             size_d;

  // Map the major opcode onto an instruction format.
  always_comb begin
    fmt = FMT_X;
    unique case (instruction[6:0])
      OP_R:                       fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR:   fmt = FMT_I;
      OP_STORE:                   fmt = FMT_S;
      OP_BRANCH:                  fmt = FMT_B;
      OP_LUI, OP_AUIPC:           fmt = FMT_U;
      OP_JAL:                     fmt = FMT_J;
      default:                    fmt = FMT_X;
    endcase
  end

  // slli/srli/srai carry funct7 in the top of the immediate field.
  assign is_shift = (instruction[6:0] == OP_IMM) && (instruction[13:12] == 2'b01);

  imm_gen u_imm_gen (
    .instruction (instruction[31:7]),
    .format      (fmt),
    .imm         (imm_d)
  );

  // Gate each field by whether the decoded format actually has it.
  always_comb begin
    func3_d = '0;
    func7_d = '0;
    r1_d    = '0;
    r2_d    = '0;
    rd_d    = '0;
    size_d  = 1'b0;
    unique case (fmt)
      FMT_R: begin
        func3_d = instruction[14:12];
        func7_d = instruction[31:25];
        r1_d    = instruction[19:15];
        r2_d    = instruction[24:20];
        rd_d    = instruction[11:7];
      end
      FMT_I: begin
        func3_d = instruction[14:12];
        r1_d    = instruction[19:15];
        rd_d    = instruction[11:7];
        if (is_shift) func7_d = instruction[31:25];
      end
      FMT_S, FMT_B: begin
        func3_d = instruction[14:12];
        r1_d    = instruction[19:15];
        r2_d    = instruction[24:20];
      end
      FMT_U, FMT_J: begin
        rd_d   = instruction[11:7];
        size_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Output registers; async reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode <= '0;
      func3  <= '0;
      func7  <= '0;
      r1     <= '0;
      r2     <= '0;
      rd     <= '0;
      imm    <= '0;
      size   <= 1'b0;
    end else begin
      opcode <= instruction[6:0];
      func3  <= func3_d;
      func7  <= func7_d;
      r1     <= r1_d;
      r2     <= r2_d;
      rd     <= rd_d;
      imm    <= imm_d;
      size   <= size_d;
    end
  end

endmodule

// File: tb/tb_riscv_decoder.sv
// Directed, table-driven bench for riscv_decoder.
module tb_riscv_decoder;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [6:0]  opcode;
  logic [4:0]  r1;
  logic [4:0]  r2;
  logic [4:0]  rd;
  logic [20:0] imm;
  logic        size;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       nm;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  rd;
    logic [20:0] imm;
    logic        size;
    logic        imm_lo_only;
  } vec_t;

  vec_t vecs[$];

  riscv_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .func3       (func3),
    .func7       (func7),
    .opcode      (opcode),
    .r1          (r1),
    .r2          (r2),
    .rd          (rd),
    .imm         (imm),
    .size        (size)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, exp);
    end
  endtask

  task automatic check_vec(input vec_t v);
    chk(v.nm, "opcode", {25'd0, opcode}, {25'd0, v.op});
    chk(v.nm, "func3",  {29'd0, func3},  {29'd0, v.f3});
    chk(v.nm, "func7",  {25'd0, func7},  {25'd0, v.f7});
    chk(v.nm, "r1",     {27'd0, r1},     {27'd0, v.r1});
    chk(v.nm, "r2",     {27'd0, r2},     {27'd0, v.r2});
    chk(v.nm, "rd",     {27'd0, rd},     {27'd0, v.rd});
    if (v.imm_lo_only)
      chk(v.nm, "imm[4:0]", {27'd0, imm[4:0]}, {27'd0, v.imm[4:0]});
    else
      chk(v.nm, "imm", {11'd0, imm}, {11'd0, v.imm});
    chk(v.nm, "size",   {31'd0, size},   {31'd0, v.size});
  endtask

  function automatic vec_t mk(string nm, logic [31:0] instr, logic [6:0] op, logic [2:0] f3,
                              logic [6:0] f7, logic [4:0] a, logic [4:0] b, logic [4:0] d,
                              logic [20:0] im, logic sz, logic lo);
    vec_t v;
    v.nm = nm; v.instr = instr; v.op = op; v.f3 = f3; v.f7 = f7;
    v.r1 = a; v.r2 = b; v.rd = d; v.imm = im; v.size = sz; v.imm_lo_only = lo;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    @(negedge clk);
    instruction = v.instr;
    @(posedge clk);
    #1;
    check_vec(v);
  endtask

  vec_t zero_v;
  vec_t v_jal;
  vec_t v_undef;
  vec_t v_lui;
  vec_t v_add;

  initial begin
    //             name        instr          op       f3    f7     r1  r2  rd  imm         sz lo
    vecs.push_back(mk("add",    32'h002080B3, 7'h33, 3'd0, 7'h00, 1,  2,  1,  21'h00000, 0, 0));
    vecs.push_back(mk("sub",    32'h405201B3, 7'h33, 3'd0, 7'h20, 4,  5,  3,  21'h00000, 0, 0));
    vecs.push_back(mk("beq",    32'h002080E3, 7'h63, 3'd0, 7'h00, 1,  2,  0,  21'h00800, 0, 0));
    vecs.push_back(mk("bne_m4", 32'hFE419EE3, 7'h63, 3'd1, 7'h00, 3,  4,  0,  21'h1FFFFC, 0, 0));
    vecs.push_back(mk("jal",    32'h000800EF, 7'h6F, 3'd0, 7'h00, 0,  0,  1,  21'h80000, 1, 0));
    vecs.push_back(mk("jal_m2", 32'hFFFFF06F, 7'h6F, 3'd0, 7'h00, 0,  0,  0,  21'h1FFFFE, 1, 0));
    vecs.push_back(mk("addi",   32'hFFF30293, 7'h13, 3'd0, 7'h00, 6,  0,  5,  21'h1FFFFF, 0, 0));
    vecs.push_back(mk("sw",     32'hFE21AE23, 7'h23, 3'd2, 7'h00, 3,  2,  0,  21'h1FFFFC, 0, 0));
    vecs.push_back(mk("lui",    32'hFFFFF3B7, 7'h37, 3'd0, 7'h00, 0,  0,  7,  21'h1FFFFF, 1, 0));
    vecs.push_back(mk("auipc",  32'h12345517, 7'h17, 3'd0, 7'h00, 0,  0,  10, 21'h12345, 1, 0));
    vecs.push_back(mk("jalr",   32'hFF8280E7, 7'h67, 3'd0, 7'h00, 5,  0,  1,  21'h1FFFF8, 0, 0));
    vecs.push_back(mk("lh",     32'h7E011083, 7'h03, 3'd1, 7'h00, 2,  0,  1,  21'h007E0, 0, 0));
    vecs.push_back(mk("slli",   32'h00521193, 7'h13, 3'd1, 7'h00, 4,  0,  3,  21'h00005, 0, 0));
    vecs.push_back(mk("srai",   32'h40315093, 7'h13, 3'd5, 7'h20, 2,  0,  1,  21'h00003, 0, 1));
    vecs.push_back(mk("undef0", 32'h0000007F, 7'h7F, 3'd0, 7'h00, 0,  0,  0,  21'h00000, 0, 0));
    vecs.push_back(mk("undef1", 32'hFFFFFFFF, 7'h7F, 3'd0, 7'h00, 0,  0,  0,  21'h00000, 0, 0));

    zero_v  = mk("reset",  32'h0,          7'h00, 3'd0, 7'h00, 0, 0, 0, 21'h0, 0, 0);
    v_jal   = vecs[4];
    v_lui   = vecs[8];
    v_add   = vecs[0];
    v_undef = vecs[14];

    // Reset asserted from time zero: outputs zero before any clock edge.
    rst = 1'b1;
    instruction = 32'hFFFFFFFF;
    #2;
    zero_v.nm = "reset_init";
    check_vec(zero_v);
    repeat (2) @(posedge clk);
    #1;
    zero_v.nm = "reset_held";
    check_vec(zero_v);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) apply(vecs[i]);

    // Outputs hold between edges even when the input changes.
    apply(v_jal);
    @(negedge clk);
    instruction = 32'h0000007F;
    #1;
    v_jal.nm = "hold_jal";
    check_vec(v_jal);
    @(posedge clk);
    #1;
    v_undef.nm = "after_hold";
    check_vec(v_undef);

    // Mid-stream reset clears outputs without waiting for an edge.
    apply(v_lui);
    #2;
    rst = 1'b1;
    #1;
    zero_v.nm = "reset_async";
    check_vec(zero_v);
    @(posedge clk);
    #1;
    zero_v.nm = "reset_mid_edge";
    check_vec(zero_v);
    @(negedge clk);
    rst = 1'b0;
    instruction = v_add.instr;
    #1;
    zero_v.nm = "released_no_edge";
    check_vec(zero_v);
    @(posedge clk);
    #1;
    v_add.nm = "first_after_reset";
    check_vec(v_add);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_decoder.md
Name: riscv_decoder

Overview:
Registered RV32I base-instruction field decoder in the front end of the single-issue core. Each rising clock edge it splits one 32-bit instruction word into opcode, func3, func7, register addresses and a sign-extended immediate. It also sets a wide-immediate flag for the U and J formats. Register-file read and ALU/branch logic downstream consume these outputs.

Parameters:
none (RV32I widths are fixed)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous active-high reset
instruction  input  32  instruction word to decode
func3  output  3  instruction[14:12] when the format has it, else 0
func7  output  7  instruction[31:25] for R-type and I-type shifts, else 0
opcode  output  7  instruction[6:0], always passed through
r1  output  5  rs1 = instruction[19:15] for R/I/S/B formats, else 0
r2  output  5  rs2 = instruction[24:20] for R/S/B formats, else 0
rd  output  5  instruction[11:7] for R/I/U/J formats, else 0
imm  output  21  sign-extended immediate for the format, else 0
size  output  1  1 = wide immediate (U or J format), 0 otherwise

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- All outputs are registered. While rst is high, every output is 0.
- Latency is one cycle. Outputs reflect the instruction sampled at the previous rising edge and hold until the next edge. There is no handshake and no enable.
- Format is selected by instruction[6:0]:
  - R, 0110011: func3, func7, r1, r2, rd valid; imm = 0.
  - I, 0010011 / 0000011 / 1100111: func3, r1, rd valid; imm = sext(inst[31:20]).
  - I-type shifts (opcode 0010011 with func3 001 or 101): func7 = inst[31:25]; imm[4:0] = shamt, upper bits still sign-extended from inst[31].
  - S, 0100011: func3, r1, r2 valid; imm = sext({inst[31:25], inst[11:7]}).
  - B, 1100011: func3, r1, r2 valid; imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}), 13 bits.
  - U, 0110111 / 0010111: rd valid; imm = {inst[31], inst[31:12]}, i.e. the 20-bit upper field sign-extended to 21 bits, unshifted (the consumer applies <<12); size = 1.
  - J, 1101111: rd valid; imm = {inst[31], inst[19:12], inst[20], inst[30:21], 0}, a full 21-bit immediate; size = 1.
- Any other opcode: opcode passes through; all other outputs are 0.
- Sign extension is always to 21 bits from the format's top immediate bit.
- Reset asserted mid-stream clears outputs immediately. The first decode after release happens at the first rising edge with rst low.

Decomposition:
- Shared package (rv32i_pkg): opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL) and a format enum {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X}.
- One sub-module: imm_gen. It is combinational: inputs are instruction and format, output is the 21-bit immediate. riscv_decoder holds the format-classify logic and the output registers.

Test Plan:
- Reset: rst = 1 with any instruction -> all outputs 0, asynchronously and without waiting for a clock edge.
- add x1,x1,x2 (0x002080B3) -> after 1 edge: opcode = 0110011, func3 = 0, func7 = 0, r1 = 1, r2 = 2, rd = 1, imm = 0, size = 0.
- beq x1,x2 (0x002080E3) -> opcode = 1100011, func3 = 0, func7 = 0, r1 = 1, r2 = 2, rd = 0, imm = 0x00800 (2048), size = 0.
- jal x1 (0x000800EF) -> opcode = 1101111, rd = 1, r1 = r2 = func3 = func7 = 0, imm = 0x80000, size = 1.
- addi x5,x6,-1 (0xFFF30293) -> r1 = 6, rd = 5, func3 = 0, imm = 0x1FFFFF, size = 0. Then sw x2,-4(x3) (0xFE21AE23) -> r1 = 3, r2 = 2, func3 = 010, imm = 0x1FFFFC.
- lui x7,0xFFFFF (0xFFFFF3B7) -> rd = 7, imm = 0x1FFFFF, size = 1. Undefined opcode 0x0000007F -> opcode = 1111111, all other outputs 0.
